adder_tree_seq: RTL and testbench



---
 rtl/adder_tree_seq_if.sv | 32 +++
 rtl/adder_tree_seq.sv | 126 ++++++++++++
 tb/tb_adder_tree_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_tree_seq_if.sv
// adder_tree_seq_if: lane bus into the adder tree and the reduced result back out.
// i_acc_last exists only when ADDER_TREE_ACC_EN is defined.
// master drives lanes/enable, slave (the tree) drives o_valid/o_data_bus.
interface adder_tree_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUT  = 8
);
  logic [NUM_INPUT-1:0]            i_valid;
  logic [NUM_INPUT*DATA_WIDTH-1:0] i_data_bus;
  logic                            i_en;
`ifdef ADDER_TREE_ACC_EN
  logic                            i_acc_last;
`endif
  logic                            o_valid;
  logic [DATA_WIDTH-1:0]           o_data_bus;

  modport master (
    output i_valid, i_data_bus, i_en,
`ifdef ADDER_TREE_ACC_EN
    output i_acc_last,
`endif
    input  o_valid, o_data_bus
  );

  modport slave (
    input  i_valid, i_data_bus, i_en,
`ifdef ADDER_TREE_ACC_EN
    input  i_acc_last,
`endif
    output o_valid, o_data_bus
  );
endinterface

// File: rtl/adder_tree_seq.sv
// adder_tree_seq: masked NUM_INPUT-lane wrap-around adder tree, one register level per tree level.
// Latency LOG2_NUM_INPUT cycles; one more with the ADDER_TREE_ACC_EN packet accumulator.
// i_en=0 freezes every stage and forces o_valid low; o_valid is the last-stage valid AND i_en.
module adder_tree_seq #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_INPUT      = 8,   // power of two, >= 2
  parameter int LOG2_NUM_INPUT = 3    // must equal log2(NUM_INPUT)
) (
  input logic             clk,
  input logic             rst,
  adder_tree_seq_if.slave bus
);
  localparam int L = LOG2_NUM_INPUT;

  typedef logic [DATA_WIDTH-1:0] word_t;

  // Heap layout: node j has children 2j and 2j+1; leaves sit at NUM_INPUT..2*NUM_INPUT-1,
  // registered sums at 1..NUM_INPUT-1, node 1 is the root.
  word_t          tree     [2:2*NUM_INPUT-1];
  word_t          node_sum [1:NUM_INPUT-1];
  word_t          node_q   [1:NUM_INPUT-1];
  logic [L:1]     vld_q;
  logic [L:0]     stg_vld;
  logic           beat;
  word_t          res_dat;
  logic           res_vld;
  word_t          hold_q;

  // Index into stg_vld of the level that feeds node j (0 = incoming beat).
  function automatic int feed_idx(input int j);
    return L - $clog2(j + 1);
  endfunction

  assign stg_vld = {vld_q, beat};

  // Mask invalid lanes to zero and splice leaves and registered nodes into one array
  always_comb begin
    for (int k = 0; k < NUM_INPUT; k++) begin
      tree[NUM_INPUT + k] = bus.i_valid[k] ? bus.i_data_bus[k*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
    for (int j = 2; j < NUM_INPUT; j++) begin
      tree[j] = node_q[j];
    end
  end

  // One wrapping DATA_WIDTH adder per node
  always_comb begin
    for (int j = 1; j < NUM_INPUT; j++) begin
      node_sum[j] = tree[2*j] + tree[2*j+1];
    end
  end

  // Advance all levels together on enabled cycles; data loads only behind a valid item
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int j = 1; j < NUM_INPUT; j++) node_q[j] <= '0;
    end else if (bus.i_en) begin
      vld_q <= stg_vld[L-1:0];
      for (int j = 1; j < NUM_INPUT; j++) begin
        if (stg_vld[feed_idx(j)]) node_q[j] <= node_sum[j];
      end
    end
  end

`ifdef ADDER_TREE_ACC_EN
  logic [L:1] lst_q;
  logic [L:0] stg_lst;
  word_t      acc_q;
  word_t      res_q;
  logic       res_vld_q;

  // An empty closing beat (no lanes valid, last set) still travels so the packet can finish
  assign beat    = (|bus.i_valid) | bus.i_acc_last;
  assign stg_lst = {lst_q, bus.i_acc_last};

  // Last flags ride alongside the valids
  always_ff @(posedge clk) begin
    if (rst) begin
      lst_q <= '0;
    end else if (bus.i_en) begin
      lst_q <= stg_lst[L-1:0];
    end
  end

  // Fold non-final tree results into the accumulator; a final one emits and clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else if (bus.i_en) begin
      res_vld_q <= 1'b0;
      if (stg_vld[L]) begin
        if (stg_lst[L]) begin
          res_q     <= acc_q + node_q[1];
          res_vld_q <= 1'b1;
          acc_q     <= '0;
        end else begin
          acc_q <= acc_q + node_q[1];
        end
      end
    end
  end

  assign res_dat = res_q;
  assign res_vld = res_vld_q;
`else
  assign beat    = |bus.i_valid;
  assign res_dat = node_q[1];
  assign res_vld = stg_vld[L];
`endif

  // Reset wins over enable, so nothing is presented while rst is high
  assign bus.o_valid    = res_vld & bus.i_en & ~rst;
  assign bus.o_data_bus = bus.o_valid ? res_dat : hold_q;

  // Keep the last transferred result on the bus between results
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (bus.o_valid) begin
      hold_q <= res_dat;
    end
  end
endmodule

// File: tb/tb_adder_tree_seq.sv
// tb_adder_tree_seq: vector table, hand sequences and random traffic against a queue model.
// Model tracks each pending result by count of enabled edges seen; it emits at the latency.
// Build with ADDER_TREE_ACC_EN defined to exercise the packet accumulator.
`timescale 1ns/1ps
module tb_adder_tree_seq;
  localparam int DW = 16;
  localparam int N  = 8;
  localparam int LG = 3;
`ifdef ADDER_TREE_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif
  localparam int LAT = ACC ? LG + 1 : LG;

  logic clk = 1'b0;
  logic rst;

  adder_tree_seq_if #(.DATA_WIDTH(DW), .NUM_INPUT(N)) bus ();

  adder_tree_seq #(.DATA_WIDTH(DW), .NUM_INPUT(N), .LOG2_NUM_INPUT(LG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] sum;
    int            age;
  } item_t;

  typedef struct {
    logic [N-1:0]    v;
    logic [N*DW-1:0] d;
    logic [DW-1:0]   exp;
  } vec_t;

  item_t         pipe[$];
  logic [DW-1:0] seen[$];
  logic [DW-1:0] hold;
  logic [DW-1:0] pkt;
  logic          last_ov;
  int            checks;
  int            errors;
  vec_t          tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the model, advance the model, wait for next negedge.
  task automatic step(input logic r, input logic [N-1:0] v, input logic [N*DW-1:0] d,
                      input logic e, input logic last);
    logic          exp_ov;
    logic [DW-1:0] exp_dat;
    logic [DW-1:0] s;
    item_t         it;
    rst            = r;
    bus.i_valid    = v;
    bus.i_data_bus = d;
    bus.i_en       = e;
`ifdef ADDER_TREE_ACC_EN
    bus.i_acc_last = last;
`endif
    #1;
    exp_ov = 1'b0;
    if (!r && e && pipe.size() > 0) exp_ov = (pipe[0].age == LAT);
    exp_dat = hold;
    if (exp_ov) exp_dat = pipe[0].sum;
    chk("o_valid", {31'd0, bus.o_valid}, {31'd0, exp_ov});
    chk("o_data_bus", {16'd0, bus.o_data_bus}, {16'd0, exp_dat});
    last_ov = bus.o_valid;
    if (bus.o_valid === 1'b1) seen.push_back(bus.o_data_bus);
    if (r) begin
      pipe.delete();
      pkt  = '0;
      hold = '0;
    end else if (e) begin
      if (exp_ov) begin
        hold = pipe[0].sum;
        void'(pipe.pop_front());
      end
      foreach (pipe[i]) pipe[i].age++;
      if ((|v) || (ACC && last)) begin
        s = '0;
        for (int k = 0; k < N; k++) if (v[k]) s = s + d[k*DW +: DW];
        it.age = 1;
        if (ACC) begin
          pkt = pkt + s;
          if (last) begin
            it.sum = pkt;
            pipe.push_back(it);
            pkt = '0;
          end
        end else begin
          it.sum = s;
          pipe.push_back(it);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] x);
    return {N{x}};
  endfunction

  initial begin
    int lat_seen;
    checks = 0;
    errors = 0;
    hold   = '0;
    pkt    = '0;
    rst            = 1'b1;
    bus.i_valid    = '1;
    bus.i_data_bus = fill(16'h0001);
    bus.i_en       = 1'b1;
`ifdef ADDER_TREE_ACC_EN
    bus.i_acc_last = 1'b0;
`endif

    tbl[0] = '{8'hFF, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 16'h0024};
    tbl[1] = '{8'h05, 128'h1234_1234_1234_1234_1234_0003_1234_FFFF, 16'h0002};
    tbl[2] = '{8'hFF, {8{16'hFFFF}},                                 16'hFFF8};
    tbl[3] = '{8'h80, 128'hABCD_1111_1111_1111_1111_1111_1111_1111, 16'hABCD};
    tbl[4] = '{8'h0A, 128'h0001_0001_0001_0001_8000_0001_8000_0001, 16'h0000};
    tbl[5] = '{8'hF0, 128'h0400_0300_0200_0100_FFFF_FFFF_FFFF_FFFF, 16'h0A00};
    tbl[6] = '{8'h01, 128'h0000_0000_0000_0000_0000_0000_0000_7FFF, 16'h7FFF};

    @(negedge clk);

    // Reset held with traffic present: nothing comes out, bus reads zero
    for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, fill(16'h0005), 1'b1, 1'b1);

    // First beat after reset: measure latency
    seen.delete();
    step(1'b0, 8'hFF, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b1, 1'b1);
    lat_seen = 0;
    for (int n = 1; n <= 10; n++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      if (last_ov === 1'b1 && lat_seen == 0) lat_seen = n;
    end
    chk("first_latency", lat_seen, LAT);
    chk("first_count", seen.size(), 1);
    if (seen.size() > 0) chk("first_sum", {16'd0, seen[0]}, 32'h0024);

    // Vector table, back to back
    seen.delete();
    for (int i = 0; i < 7; i++) step(1'b0, tbl[i].v, tbl[i].d, 1'b1, 1'b1);
    idle(LAT + 2);
    chk("table_count", seen.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < seen.size()) chk($sformatf("table_%0d", i), {16'd0, seen[i]}, {16'd0, tbl[i].exp});
    end

    // No valid lanes: no result
    seen.delete();
    step(1'b0, 8'h00, fill(16'h7777), 1'b1, 1'b0);
    idle(LAT + 2);
    chk("no_lane_count", seen.size(), 0);

    // Stall of two cycles in the middle of four beats
    seen.delete();
    step(1'b0, 8'hFF, fill(16'd1), 1'b1, 1'b1);
    step(1'b0, 8'hFF, fill(16'd2), 1'b1, 1'b1);
    step(1'b0, 8'hFF, fill(16'd9), 1'b0, 1'b1);
    step(1'b0, 8'hFF, fill(16'd9), 1'b0, 1'b1);
    step(1'b0, 8'hFF, fill(16'd3), 1'b1, 1'b1);
    step(1'b0, 8'hFF, fill(16'd4), 1'b1, 1'b1);
    idle(LAT + 3);
    chk("stall_count", seen.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < seen.size()) chk($sformatf("stall_%0d", i), {16'd0, seen[i]}, 8 * (i + 1));
    end

    // Reset with three beats in flight: none ever emerges
    seen.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, fill(16'd3), 1'b1, 1'b1);
    step(1'b1, 8'hFF, fill(16'd3), 1'b1, 1'b1);
    idle(LAT + 3);
    chk("rst_mid_count", seen.size(), 0);
    step(1'b0, 8'hFF, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b1, 1'b1);
    idle(LAT + 2);
    chk("after_rst_count", seen.size(), 1);
    if (seen.size() > 0) chk("after_rst_sum", {16'd0, seen[0]}, 32'h0024);

`ifdef ADDER_TREE_ACC_EN
    // Packet of 10, 20, 30 then a single-beat packet of 5
    seen.delete();
    step(1'b0, 8'h01, {112'd0, 16'd10}, 1'b1, 1'b0);
    step(1'b0, 8'h01, {112'd0, 16'd20}, 1'b1, 1'b0);
    step(1'b0, 8'h01, {112'd0, 16'd30}, 1'b1, 1'b1);
    idle(LAT + 2);
    step(1'b0, 8'h01, {112'd0, 16'd5}, 1'b1, 1'b1);
    idle(LAT + 2);
    chk("acc_count", seen.size(), 2);
    if (seen.size() > 1) begin
      chk("acc_sum", {16'd0, seen[0]}, 32'd60);
      chk("acc_cleared", {16'd0, seen[1]}, 32'd5);
    end
`endif

    // Random traffic with stalls and occasional resets
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0]    rv;
      logic [N*DW-1:0] rd;
      rv = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      rd = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 60) == 0), rv, rd, ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 2) == 0));
    end
    idle(LAT + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
